// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button front end.
// Holds the repeat FSM state encoding and counter sizing.
package button_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      RPT  = 2'd2
   } rpt_state_t;

   // Bits needed to hold values 0..n
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_channel.sv
// One button: synchroniser, debounce, press/release pulses
// and the long-press auto-repeat FSM.
module button_channel
   import button_pkg::*;
#(
   parameter int ACTIVE_LOW   = 1,
   parameter int DEB_CYCLES   = 50000,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000,
   parameter bit REPEAT_EN    = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press_evt,
   output logic release_evt,
   output logic repeat_evt
);

   localparam int DW = cnt_width(DEB_CYCLES);
   localparam int TW = cnt_width(max2(REPEAT_DELAY, REPEAT_RATE));
   localparam logic REL_PIN = (ACTIVE_LOW != 0);
   localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
   localparam logic [TW-1:0] DLY_MAX = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] RPT_MAX = TW'(REPEAT_RATE - 1);

   logic          s1;
   logic          s2;
   logic          sync_on;
   logic [DW-1:0] cnt;
   logic          mismatch;
   logic          hit;
   logic          rise;
   logic          fall;

   rpt_state_t    state_q;
   rpt_state_t    state_d;
   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;
   logic          pulse_d;

   // Two-flop synchroniser, preset to the released pin level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= REL_PIN;
         s2 <= REL_PIN;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   assign sync_on  = s2 ^ REL_PIN;
   assign mismatch = sync_on != level;
   assign hit      = mismatch && (cnt == DEB_MAX);
   assign rise     = hit && !level;
   assign fall     = hit && level;

   // Debounce counter, accepted level and edge pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         level       <= 1'b0;
         press_evt   <= 1'b0;
         release_evt <= 1'b0;
      end else begin
         press_evt   <= rise;
         release_evt <= fall;
         if (hit) begin
            level <= ~level;
            cnt   <= '0;
         end else if (mismatch) begin
            cnt <= cnt + DW'(1);
         end else begin
            cnt <= '0;
         end
      end
   end

   // Repeat FSM state, timer and registered repeat pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         repeat_evt <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         repeat_evt <= pulse_d;
      end
   end

   // Repeat FSM next state; channels without repeat stay in IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (rise) state_d = REPEAT_EN ? HOLD : IDLE;
         HOLD: begin
            if (fall) state_d = IDLE;
            else if (timer_q == DLY_MAX) state_d = RPT;
         end
         RPT:  if (fall) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Repeat FSM outputs: pulse request and timer update
   always_comb begin
      pulse_d = 1'b0;
      timer_d = timer_q + TW'(1);
      unique case (state_q)
         IDLE: begin
            timer_d = '0;
            pulse_d = rise;
         end
         HOLD: begin
            if (fall) begin
               timer_d = '0;
            end else if (timer_q == DLY_MAX) begin
               timer_d = '0;
               pulse_d = 1'b1;
            end
         end
         RPT: begin
            if (fall) begin
               timer_d = '0;
            end else if (timer_q == RPT_MAX) begin
               timer_d = '0;
               pulse_d = 1'b1;
            end
         end
         default: timer_d = '0;
      endcase
   end

endmodule

// File: rtl/button_hub.sv
// Push-button hub: per-channel conditioning plus a
// wrap-around mode counter driven by one button.
module button_hub
   import button_pkg::*;
#(
   parameter int NUM_BTN      = 3,
   parameter int ACTIVE_LOW   = 1,
   parameter int DEB_CYCLES   = 50000,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000,
   parameter int NUM_MODES    = 5,
   parameter int MODE_BTN     = 2
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [NUM_BTN-1:0]           BTN_RAW,
   output logic [NUM_BTN-1:0]           BTN_LEVEL,
   output logic [NUM_BTN-1:0]           BTN_PRESS,
   output logic [NUM_BTN-1:0]           BTN_RELEASE,
   output logic [NUM_BTN-1:0]           BTN_REPEAT,
   output logic [$clog2(NUM_MODES)-1:0] MODE,
   output logic                         MODE_CHANGE
);

   localparam int MW = $clog2(NUM_MODES);
   localparam logic [MW-1:0] MODE_LAST = MW'(NUM_MODES - 1);

   if (NUM_BTN < 1) begin : g_bad_nbtn
      $fatal(1, "button_hub: NUM_BTN must be >= 1");
   end
   if (DEB_CYCLES < 1) begin : g_bad_deb
      $fatal(1, "button_hub: DEB_CYCLES must be >= 1");
   end
   if (REPEAT_DELAY < 1) begin : g_bad_dly
      $fatal(1, "button_hub: REPEAT_DELAY must be >= 1");
   end
   if (REPEAT_RATE < 1) begin : g_bad_rate
      $fatal(1, "button_hub: REPEAT_RATE must be >= 1");
   end
   if (NUM_MODES < 2) begin : g_bad_modes
      $fatal(1, "button_hub: NUM_MODES must be >= 2");
   end
   if (MODE_BTN < 0 || MODE_BTN >= NUM_BTN) begin : g_bad_mbtn
      $fatal(1, "button_hub: MODE_BTN out of range");
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      button_channel #(
         .ACTIVE_LOW   (ACTIVE_LOW),
         .DEB_CYCLES   (DEB_CYCLES),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE),
         .REPEAT_EN    (i != MODE_BTN)
      ) u_ch (
         .clk         (CLK),
         .rst         (RST),
         .raw         (BTN_RAW[i]),
         .level       (BTN_LEVEL[i]),
         .press_evt   (BTN_PRESS[i]),
         .release_evt (BTN_RELEASE[i]),
         .repeat_evt  (BTN_REPEAT[i])
      );
   end

   // Mode counter: advance and wrap on each press of the mode button
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         MODE        <= '0;
         MODE_CHANGE <= 1'b0;
      end else begin
         MODE_CHANGE <= BTN_PRESS[MODE_BTN];
         if (BTN_PRESS[MODE_BTN]) begin
            MODE <= (MODE == MODE_LAST) ? '0 : MODE + MW'(1);
         end
      end
   end

endmodule
